// File: rtl/shift_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_register_pkg
// Description : Shared definitions for the universal shift register: the
//               operating-mode encodings and a helper that sizes the button
//               debounce counter.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_register_pkg;

  // Operating modes selected by the two mode switches.
  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_ARITH  = 2'b10;
  localparam logic [1:0] MODE_LOAD   = 2'b11;

  // The debounce counter must be able to hold DEBOUNCE_CYCLES-1.
  function automatic int debounce_cnt_width(input int cycles);
    if (cycles <= 2) begin
      return 1;
    end
    return $clog2(cycles);
  endfunction

endpackage : shift_register_pkg
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Synchronises and debounces one active-low push button and
//               emits a single-cycle pulse on each accepted press.
// Ports       : clk     - system clock
//               reset   - synchronous, active-high reset
//               btn_n   - raw asynchronous button, low = pressed
//               press   - registered one-cycle pulse on released->pressed
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
  import shift_register_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int                 c_CNT_W   = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;   // 1 = pressed
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_press;
  logic               w_pressed;
  logic               w_differs;
  logic               w_flip;

  // Synchroniser flops idle at 1 so a reset looks like a released button.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;
  assign w_differs = (w_pressed != r_stable);
  assign w_flip    = w_differs && (r_cnt == c_CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      // Pulse only when the flip is towards the pressed state.
      r_press <= w_flip && w_pressed;
      if (w_flip) begin
        r_stable <= w_pressed;
        r_cnt    <= '0;
      end else if (w_differs) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign press = r_press;

endmodule : button_debounce
`default_nettype wire

// File: rtl/shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module      : shift_register_universal
// Description : WIDTH-bit register driven by two debounced push buttons.
//               Each accepted press performs one shift, rotate, arithmetic
//               shift or parallel load depending on the mode switches.
// Ports       : clk           - system clock
//               reset         - synchronous, active-high reset
//               btn_left_n    - raw button, active-low, operate towards MSB
//               btn_right_n   - raw button, active-low, operate towards LSB
//               sw_mode       - raw mode switches
//               sw_fill_left  - raw bit entering MSB on a plain right shift
//               sw_fill_right - raw bit entering LSB on a plain left shift
//               sw_data       - raw parallel-load value
//               leds          - register contents
//               shift_out     - bit that left on the last shift/rotate
//               op_count      - executed operations, wraps on overflow
// Revision    : 1.0 - initial release
// ============================================================================
module shift_register_universal
  import shift_register_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_left_n,
  input  logic               btn_right_n,
  input  logic [1:0]         sw_mode,
  input  logic               sw_fill_left,
  input  logic               sw_fill_right,
  input  logic [WIDTH-1:0]   sw_data,
  output logic [WIDTH-1:0]   leds,
  output logic               shift_out,
  output logic [COUNT_W-1:0] op_count
);

  logic               w_press_left;
  logic               w_press_right;

  logic [1:0]         r_mode_s1,  r_mode_s2;
  logic               r_fl_s1,    r_fl_s2;
  logic               r_fr_s1,    r_fr_s2;
  logic [WIDTH-1:0]   r_data_s1,  r_data_s2;

  logic [WIDTH-1:0]   r_reg;
  logic               r_shift_out;
  logic [COUNT_W-1:0] r_op_count;

  logic [WIDTH-1:0]   w_next_reg;
  logic               w_next_so;
  logic               w_exec;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_left (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_left_n),
    .press (w_press_left)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_right (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_right_n),
    .press (w_press_right)
  );

  // Two-flop synchronisers for every switch input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_s1 <= '0;
      r_mode_s2 <= '0;
      r_fl_s1   <= 1'b0;
      r_fl_s2   <= 1'b0;
      r_fr_s1   <= 1'b0;
      r_fr_s2   <= 1'b0;
      r_data_s1 <= '0;
      r_data_s2 <= '0;
    end else begin
      r_mode_s1 <= sw_mode;
      r_mode_s2 <= r_mode_s1;
      r_fl_s1   <= sw_fill_left;
      r_fl_s2   <= r_fl_s1;
      r_fr_s1   <= sw_fill_right;
      r_fr_s2   <= r_fr_s1;
      r_data_s1 <= sw_data;
      r_data_s2 <= r_data_s1;
    end
  end

  // Operation mux. Simultaneous left and right pulses cancel each other.
  always_comb begin
    w_next_reg = r_reg;
    w_next_so  = r_shift_out;
    w_exec     = 1'b0;
    if (w_press_left ^ w_press_right) begin
      w_exec = 1'b1;
      case (r_mode_s2)
        MODE_SHIFT: begin
          if (w_press_left) begin
            w_next_reg = {r_reg[WIDTH-2:0], r_fr_s2};
            w_next_so  = r_reg[WIDTH-1];
          end else begin
            w_next_reg = {r_fl_s2, r_reg[WIDTH-1:1]};
            w_next_so  = r_reg[0];
          end
        end
        MODE_ROTATE: begin
          if (w_press_left) begin
            w_next_reg = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
            w_next_so  = r_reg[WIDTH-1];
          end else begin
            w_next_reg = {r_reg[0], r_reg[WIDTH-1:1]};
            w_next_so  = r_reg[0];
          end
        end
        MODE_ARITH: begin
          if (w_press_left) begin
            w_next_reg = {r_reg[WIDTH-2:0], 1'b0};
            w_next_so  = r_reg[WIDTH-1];
          end else begin
            w_next_reg = {r_reg[WIDTH-1], r_reg[WIDTH-1:1]};
            w_next_so  = r_reg[0];
          end
        end
        default: begin
          // MODE_LOAD: either button loads; shift_out keeps its value.
          w_next_reg = r_data_s2;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg       <= '0;
      r_shift_out <= 1'b0;
      r_op_count  <= '0;
    end else if (w_exec) begin
      r_reg       <= w_next_reg;
      r_shift_out <= w_next_so;
      r_op_count  <= r_op_count + COUNT_W'(1);
    end
  end

  assign leds      = r_reg;
  assign shift_out = r_shift_out;
  assign op_count  = r_op_count;

endmodule : shift_register_universal
`default_nettype wire

// File: tb/tb_shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_register_universal
// Description : Self-checking bench for shift_register_universal with
//               directed scenarios and a randomized run against a simple
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_register_universal;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;
  localparam int CW    = 8;
  localparam int LAT   = DEB + 2;   // edges from first low sample to update

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_left_n;
  logic             btn_right_n;
  logic [1:0]       sw_mode;
  logic             sw_fill_left;
  logic             sw_fill_right;
  logic [WIDTH-1:0] sw_data;
  logic [WIDTH-1:0] leds;
  logic             shift_out;
  logic [CW-1:0]    op_count;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  int m_reg;
  int m_so;
  int m_cnt;

  always #5 clk = ~clk;

  shift_register_universal #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEB),
    .COUNT_W         (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_left_n    (btn_left_n),
    .btn_right_n   (btn_right_n),
    .sw_mode       (sw_mode),
    .sw_fill_left  (sw_fill_left),
    .sw_fill_right (sw_fill_right),
    .sw_data       (sw_data),
    .leds          (leds),
    .shift_out     (shift_out),
    .op_count      (op_count)
  );

  // Reference operation, described as integer arithmetic on the value.
  task automatic model_op(input int mode, input bit left,
                          output int nreg, output int nso);
    int msb, lsb;
    msb = m_reg / 128;
    lsb = m_reg % 2;
    nso = m_so;
    if (mode == 3) begin
      nreg = int'(sw_data);
    end else if (left) begin
      nso = msb;
      case (mode)
        0:       nreg = (m_reg * 2) % 256 + int'(sw_fill_right);
        1:       nreg = (m_reg * 2) % 256 + msb;
        default: nreg = (m_reg * 2) % 256;
      endcase
    end else begin
      nso = lsb;
      case (mode)
        0:       nreg = m_reg / 2 + 128 * int'(sw_fill_left);
        1:       nreg = m_reg / 2 + 128 * lsb;
        default: nreg = m_reg / 2 + 128 * msb;
      endcase
    end
  endtask

  task automatic set_sw(input logic [1:0] mode, input logic [7:0] data,
                        input logic fl, input logic fr);
    @(negedge clk);
    sw_mode       = mode;
    sw_data       = data;
    sw_fill_left  = fl;
    sw_fill_right = fr;
    repeat (3) @(posedge clk);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    btn_left_n  = 1'b1;
    btn_right_n = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reg = 0; m_so = 0; m_cnt = 0;
  endtask

  // Press one button for 'hold' cycles, checking the update lands exactly
  // LAT edges after the first low sample, then release and let it settle.
  task automatic do_press(input bit left, input int hold, input string tag);
    int nreg, nso;
    model_op(int'(sw_mode), left, nreg, nso);
    @(negedge clk);
    if (left) btn_left_n = 1'b0; else btn_right_n = 1'b0;
    for (int e = 0; e < hold; e++) begin
      @(posedge clk); #1;
      vectors++;
      if (e < LAT) begin
        if (leds !== 8'(m_reg)) begin
          errors++;
          $display("FAIL %s early edge %0d: leds=%h expected %h", tag, e, leds, 8'(m_reg));
        end
      end else begin
        if (leds !== 8'(nreg)) begin
          errors++;
          $display("FAIL %s edge %0d: leds=%h expected %h", tag, e, leds, 8'(nreg));
        end
      end
      if (e == LAT) begin
        vectors++;
        if (shift_out !== 1'(nso) || op_count !== 8'((m_cnt + 1) % 256)) begin
          errors++;
          $display("FAIL %s so/count: so=%b cnt=%0d expected so=%b cnt=%0d",
                   tag, shift_out, op_count, 1'(nso), (m_cnt + 1) % 256);
        end
      end
    end
    m_reg = nreg; m_so = nso; m_cnt = (m_cnt + 1) % 256;
    @(negedge clk);
    btn_left_n  = 1'b1;
    btn_right_n = 1'b1;
    repeat (DEB + 4) @(posedge clk);
    #1;
    vectors++;
    if (leds !== 8'(m_reg) || op_count !== 8'(m_cnt)) begin
      errors++;
      $display("FAIL %s release: leds=%h cnt=%0d expected leds=%h cnt=%0d",
               tag, leds, op_count, 8'(m_reg), m_cnt);
    end
  endtask

  task automatic check_state(input logic [7:0] exp_leds, input logic exp_so,
                             input logic [7:0] exp_cnt, input string tag);
    vectors++;
    if (leds !== exp_leds || shift_out !== exp_so || op_count !== exp_cnt) begin
      errors++;
      $display("FAIL %s: leds=%h so=%b cnt=%0d expected leds=%h so=%b cnt=%0d",
               tag, leds, shift_out, op_count, exp_leds, exp_so, exp_cnt);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    #1;
    check_state(8'h00, 1'b0, 8'd0, "reset");
  endtask

  task automatic test_load_hold();
    set_sw(2'b11, 8'hA5, 1'b0, 1'b0);
    do_press(1'b1, 12, "load_hold");
    check_state(8'hA5, 1'b0, 8'd1, "load_value");
  endtask

  task automatic test_rotate();
    set_sw(2'b01, 8'h00, 1'b0, 1'b0);
    do_press(1'b0, LAT + 2, "rot_right");
    check_state(8'hD2, 1'b1, 8'd2, "rot_right_value");
    do_press(1'b1, LAT + 2, "rot_left");
    check_state(8'hA5, 1'b1, 8'd3, "rot_left_value");
  endtask

  task automatic test_arith_shift();
    set_sw(2'b11, 8'h80, 1'b0, 1'b0);
    do_press(1'b1, LAT + 2, "load80");
    set_sw(2'b10, 8'h00, 1'b0, 1'b0);
    do_press(1'b0, LAT + 2, "arith_right");
    check_state(8'hC0, 1'b0, 8'd5, "arith_right_value");
    do_press(1'b1, LAT + 2, "arith_left");
    check_state(8'h80, 1'b1, 8'd6, "arith_left_value");
    set_sw(2'b00, 8'h00, 1'b0, 1'b1);
    do_press(1'b1, LAT + 2, "shift_left");
    check_state(8'h01, 1'b1, 8'd7, "shift_left_value");
  endtask

  task automatic test_glitch_and_both();
    logic [7:0] l0; logic s0; logic [7:0] c0;
    l0 = 8'(m_reg); s0 = 1'(m_so); c0 = 8'(m_cnt);
    set_sw(2'b01, 8'h00, 1'b0, 1'b0);
    @(negedge clk); btn_right_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); btn_right_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_state(l0, s0, c0, "glitch");
    @(negedge clk); btn_left_n = 1'b0; btn_right_n = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      check_state(l0, s0, c0, "both_pressed");
    end
    @(negedge clk); btn_left_n = 1'b1; btn_right_n = 1'b1;
    repeat (DEB + 4) @(posedge clk);
    #1;
    check_state(l0, s0, c0, "both_released");
  endtask

  task automatic test_reset_mid_debounce();
    set_sw(2'b11, 8'h3C, 1'b0, 1'b0);
    @(negedge clk); btn_left_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state(8'h00, 1'b0, 8'd0, "reset_mid");
    @(negedge clk); reset = 1'b0;
    m_reg = 0; m_so = 0; m_cnt = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (e < LAT) check_state(8'h00, 1'b0, 8'd0, "held_after_reset_early");
      else         check_state(8'h3C, 1'b0, 8'd1, "held_after_reset");
    end
    m_reg = 'h3C; m_cnt = 1;
    @(negedge clk); btn_left_n = 1'b1;
    repeat (DEB + 4) @(posedge clk);
    #1;
    check_state(8'h3C, 1'b0, 8'd1, "held_release");
  endtask

  task automatic test_random_wrap();
    apply_reset(2);
    for (int i = 0; i < 256; i++) begin
      set_sw(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom));
      do_press(1'($urandom), LAT + 1 + int'($urandom_range(0, 3)), "random");
    end
    check_state(8'(m_reg), 1'(m_so), 8'd0, "count_wrap");
  endtask

  initial begin
    reset = 1'b1; btn_left_n = 1'b1; btn_right_n = 1'b1;
    sw_mode = 2'b00; sw_fill_left = 1'b0; sw_fill_right = 1'b0; sw_data = '0;
    m_reg = 0; m_so = 0; m_cnt = 0;
    test_reset();
    test_load_hold();
    test_rotate();
    test_arith_shift();
    test_glitch_and_both();
    test_reset_mid_debounce();
    test_random_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_shift_register_universal
`default_nettype wire

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised successor to the board-level shift register. It debounces two active-low push buttons and synchronises all switch inputs. Each qualified press executes one operation on a WIDTH-bit register in one of four modes: serial shift, rotate, arithmetic shift, or parallel load. Register contents drive the LEDs directly; the last bit shifted out and a running operation count are also exported.

## Interface
Parameters:
- WIDTH, 8: register width; must be ≥ 2.
- DEBOUNCE_CYCLES, 16: cycles an input must be stable before a press is accepted; must be ≥ 2.
- COUNT_W, 8: width of the operation counter.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: reset, synchronous, active-high.
- btn_left_n, input, 1: raw button, active-low, asynchronous; requests a left operation (toward MSB).
- btn_right_n, input, 1: raw button, active-low, asynchronous; requests a right operation (toward LSB).
- sw_mode, input, 2: raw mode switches, asynchronous.
- sw_fill_left, input, 1: raw fill bit entering the MSB on a right shift in MODE_SHIFT.
- sw_fill_right, input, 1: raw fill bit entering the LSB on a left shift in MODE_SHIFT.
- sw_data, input, WIDTH: raw parallel-load value.
- leds, output, WIDTH: register contents.
- shift_out, output, 1: the bit that left the register on the last shift or rotate.
- op_count, output, COUNT_W: number of executed operations; wraps on overflow.

## Operation
- Every raw input passes through a 2-flop synchroniser. The buttons are inverted after synchronisation, so 1 means pressed.
- Each button has its own debouncer:
  - It holds a stable state and a counter.
  - While the synchronised value differs from the stable state, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the value still differs, the stable state flips and the counter clears.
  - Any cycle where the value equals the stable state clears the counter.
  - On each released→pressed flip of the stable state, the debouncer emits a registered one-cycle press pulse. A held button produces exactly one pulse. Releasing a button produces no pulse.
- Operations on a pulse, in the active mode:
  - MODE_SHIFT (00):
    - Left: reg ← {reg[W-2:0], fill_right}; shift_out ← reg[W-1].
    - Right: reg ← {fill_left, reg[W-1:1]}; shift_out ← reg[0].
  - MODE_ROTATE (01):
    - Left: reg ← {reg[W-2:0], reg[W-1]}; shift_out ← reg[W-1].
    - Right: reg ← {reg[0], reg[W-1:1]}; shift_out ← reg[0].
  - MODE_ARITH (10):
    - Left: reg ← {reg[W-2:0], 0}.
    - Right: reg ← {reg[W-1], reg[W-1:1]} (sign preserved).
    - shift_out behaves as in MODE_SHIFT.
  - MODE_LOAD (11): either pulse does reg ← synchronised sw_data; shift_out is unchanged.
- The mode, fill and data values used are those sampled by the synchroniser in the cycle the pulse is high.
- If left and right pulses occur in the same cycle, no operation is executed: reg, shift_out and op_count all hold.
- op_count increments by 1 per executed operation, modulo 2^COUNT_W.

## Timing
- Reset puts every output and every internal stage in a known state:
  - leds = 0, shift_out = 0, op_count = 0.
  - Debouncer stable states = released; debounce counters = 0; press pulses = 0.
  - Button synchroniser flops = 1 (released); switch synchroniser flops = 0.
- Reset takes priority over every other event. Reset asserted mid-debounce discards the pending press.
- A button still held when reset deasserts is debounced afresh and yields one press.
- Press latency: if raw low is first sampled at edge 0:
  - the stable state flips at edge DEBOUNCE_CYCLES+1;
  - the pulse is high after that edge;
  - leds, shift_out and op_count update at edge DEBOUNCE_CYCLES+2.
- A bounce shorter than DEBOUNCE_CYCLES cycles is ignored.
- Switch-to-effect latency is 2 cycles.

## Structure
- Package shift_register_pkg holds:
  - MODE_SHIFT, MODE_ROTATE, MODE_ARITH, MODE_LOAD as 2-bit localparams;
  - a helper function computing the counter width from DEBOUNCE_CYCLES.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES) is instantiated twice. It contains the synchroniser, counter, stable state and registered press pulse.
- The top level contains the switch synchronisers, the operation mux, shift_out and op_count.

## Test plan
All scenarios use WIDTH=8, DEBOUNCE_CYCLES=4, COUNT_W=8.
- Reset held 3 cycles with buttons released → leds=00, shift_out=0, op_count=0.
- MODE_LOAD, sw_data=A5, btn_left_n held low for 12 cycles → leds=A5 at edge 6 after the first low sample, op_count=1, no further change while held.
- MODE_ROTATE from A5:
  - right press → leds=D2, shift_out=1;
  - then left press → leds=A5, shift_out=1;
  - op_count=3.
- MODE_ARITH with leds=80: right press → C0; left press → 80, shift_out=1. MODE_SHIFT with fill_right=1 from 80: left press → 01, shift_out=1.
- Glitch and simultaneous press:
  - btn_right_n low for 3 cycles then high → no change;
  - both buttons pressed in the same cycle → leds, shift_out and op_count unchanged.
- Reset asserted 2 cycles into a debounce → all outputs 0, no operation. Button kept held after reset → exactly one operation at edge 6 after reset deasserts. 256 operations from reset → op_count wraps to 0.
